// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// The defaults describe 800x600 @ 60 Hz with a 40 MHz pixel clock.
package vga_timing_pkg;

    typedef logic [10:0] coord_t;

    localparam int COORD_MAX = 2047;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BACK    = 88;

    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int H_TOTAL      = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int V_TOTAL      = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
    localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and a
// visible flag decoded from the next count, so the parent can register it in step.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   VISIBLE     = DEF_H_VISIBLE,
    parameter int   FRONT       = DEF_H_FRONT,
    parameter int   SYNC        = DEF_H_SYNC,
    parameter int   BACK        = DEF_H_BACK,
    parameter logic SYNC_ACTIVE = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   visible,
    output logic   sync
);

    localparam int     TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t VIS_END    = coord_t'(VISIBLE);
    localparam coord_t SYNC_START = coord_t'(VISIBLE + FRONT);
    localparam coord_t SYNC_END   = coord_t'(VISIBLE + FRONT + SYNC);

    generate
        if (TOTAL > COORD_MAX || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_bad_params
            $error("vga_axis_counter: total exceeds 2047 or a porch/sync width is zero");
        end
    endgenerate

    coord_t count_reg;
    coord_t count_next;
    logic   sync_reg;
    logic   sync_next;

    always_comb begin
        wrap       = en && (count_reg == LAST);
        count_next = count_reg;
        if (en) begin
            count_next = wrap ? '0 : count_reg + coord_t'(1);
        end
        visible   = (count_next < VIS_END);
        sync_next = (count_next >= SYNC_START && count_next < SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            sync_reg  <= ~SYNC_ACTIVE;
        end else begin
            count_reg <= count_next;
            sync_reg  <= sync_next;
        end
    end

    assign count = count_reg;
    assign sync  = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: horizontal and vertical axis counters plus
// a registered visible-area flag aligned with the pixel coordinates.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE    = DEF_H_VISIBLE,
    parameter int   H_FRONT      = DEF_H_FRONT,
    parameter int   H_SYNC       = DEF_H_SYNC,
    parameter int   H_BACK       = DEF_H_BACK,
    parameter int   V_VISIBLE    = DEF_V_VISIBLE,
    parameter int   V_FRONT      = DEF_V_FRONT,
    parameter int   V_SYNC       = DEF_V_SYNC,
    parameter int   V_BACK       = DEF_V_BACK,
    parameter logic HSYNC_ACTIVE = 1'b1,
    parameter logic VSYNC_ACTIVE = 1'b1
) (
    input  logic   CLK_PIXEL,
    output logic   VGA_HSYNC,
    output logic   VGA_VSYNC,
    output coord_t pixel_x,
    output coord_t pixel_y,
    output logic   on_screen,
    input  logic   RESET
);

    logic h_wrap;
    logic h_visible;
    logic v_visible;
    logic v_wrap_unused;
    logic on_screen_reg;

    vga_axis_counter #(
        .VISIBLE     (H_VISIBLE),
        .FRONT       (H_FRONT),
        .SYNC        (H_SYNC),
        .BACK        (H_BACK),
        .SYNC_ACTIVE (HSYNC_ACTIVE)
    ) u_h_axis (
        .clk     (CLK_PIXEL),
        .rst     (RESET),
        .en      (1'b1),
        .count   (pixel_x),
        .wrap    (h_wrap),
        .visible (h_visible),
        .sync    (VGA_HSYNC)
    );

    // The vertical axis steps on the same edge the horizontal axis wraps.
    vga_axis_counter #(
        .VISIBLE     (V_VISIBLE),
        .FRONT       (V_FRONT),
        .SYNC        (V_SYNC),
        .BACK        (V_BACK),
        .SYNC_ACTIVE (VSYNC_ACTIVE)
    ) u_v_axis (
        .clk     (CLK_PIXEL),
        .rst     (RESET),
        .en      (h_wrap),
        .count   (pixel_y),
        .wrap    (v_wrap_unused),
        .visible (v_visible),
        .sync    (VGA_VSYNC)
    );

    // (0,0) is visible, so the flag resets high.
    always_ff @(posedge CLK_PIXEL or posedge RESET) begin
        if (RESET) begin
            on_screen_reg <= 1'b1;
        end else begin
            on_screen_reg <= h_visible && v_visible;
        end
    end

    assign on_screen = on_screen_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance plus a tiny active-low instance
// small enough to cover whole frames, checked against a position model.
module tb_vga_timing_gen;

    localparam int DH_VIS = 800, DH_SS = 840, DH_SE = 968, DH_TOT = 1056;
    localparam int DV_VIS = 600, DV_SS = 601, DV_SE = 605, DV_TOT = 628;
    localparam int SH_VIS = 8,   SH_SS = 10,  SH_SE = 13,  SH_TOT = 15;
    localparam int SV_VIS = 6,   SV_SS = 7,   SV_SE = 9,   SV_TOT = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_hs, d_vs, d_on, s_hs, s_vs, s_on;
    logic [10:0] d_x, d_y, s_x, s_y;

    int checks = 0;
    int errors = 0;
    int dx, dy, sx, sy;
    int cyc;
    logic prev_dhs, prev_shs, prev_svs;
    int d_hs_rise, d_hs_width, s_vs_fall, s_vs_width, s_hs_width;

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .CLK_PIXEL (clk),
        .VGA_HSYNC (d_hs),
        .VGA_VSYNC (d_vs),
        .pixel_x   (d_x),
        .pixel_y   (d_y),
        .on_screen (d_on),
        .RESET     (rst)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2),
        .HSYNC_ACTIVE (1'b0), .VSYNC_ACTIVE (1'b0)
    ) u_small (
        .CLK_PIXEL (clk),
        .VGA_HSYNC (s_hs),
        .VGA_VSYNC (s_vs),
        .pixel_x   (s_x),
        .pixel_y   (s_y),
        .on_screen (s_on),
        .RESET     (rst)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_d_x", 32'(d_x), 0);
        chk("rst_d_y", 32'(d_y), 0);
        chk("rst_d_on", 32'(d_on), 1);
        chk("rst_d_hs", 32'(d_hs), 0);
        chk("rst_d_vs", 32'(d_vs), 0);
        chk("rst_s_x", 32'(s_x), 0);
        chk("rst_s_y", 32'(s_y), 0);
        chk("rst_s_on", 32'(s_on), 1);
        chk("rst_s_hs", 32'(s_hs), 1);
        chk("rst_s_vs", 32'(s_vs), 1);
    endtask

    task automatic model_restart();
        dx = 0; dy = 0; sx = 0; sy = 0;
        prev_dhs = 1'b0; prev_shs = 1'b1; prev_svs = 1'b1;
        d_hs_rise = -1; s_vs_fall = -1;
        d_hs_width = 0; s_vs_width = 0; s_hs_width = 0;
    endtask

    // One clock: advance the model, then compare every output at the negedge.
    task automatic tick_check();
        @(posedge clk);
        cyc++;
        if (dx == DH_TOT - 1) begin
            dx = 0;
            dy = (dy == DV_TOT - 1) ? 0 : dy + 1;
        end else dx++;
        if (sx == SH_TOT - 1) begin
            sx = 0;
            sy = (sy == SV_TOT - 1) ? 0 : sy + 1;
        end else sx++;
        @(negedge clk);
        chk("d_x", 32'(d_x), 32'(dx));
        chk("d_y", 32'(d_y), 32'(dy));
        chk("d_on", 32'(d_on), 32'(dx < DH_VIS && dy < DV_VIS));
        chk("d_hs", 32'(d_hs), 32'(dx >= DH_SS && dx < DH_SE));
        chk("d_vs", 32'(d_vs), 32'(dy >= DV_SS && dy < DV_SE));
        chk("s_x", 32'(s_x), 32'(sx));
        chk("s_y", 32'(s_y), 32'(sy));
        chk("s_on", 32'(s_on), 32'(sx < SH_VIS && sy < SV_VIS));
        chk("s_hs", 32'(s_hs), 32'(!(sx >= SH_SS && sx < SH_SE)));
        chk("s_vs", 32'(s_vs), 32'(!(sy >= SV_SS && sy < SV_SE)));
        // Pulse widths and periods measured directly on the outputs.
        if (d_hs && !prev_dhs) begin
            if (d_hs_rise >= 0) chk("d_hs_period", 32'(cyc - d_hs_rise), 1056);
            d_hs_rise = cyc;
            d_hs_width = 0;
        end
        if (d_hs) d_hs_width++;
        if (!d_hs && prev_dhs) chk("d_hs_width", 32'(d_hs_width), 128);
        if (!s_vs && prev_svs) begin
            if (s_vs_fall >= 0) chk("s_vs_period", 32'(cyc - s_vs_fall), 165);
            s_vs_fall = cyc;
            s_vs_width = 0;
        end
        if (!s_vs) s_vs_width++;
        if (s_vs && !prev_svs) chk("s_vs_width", 32'(s_vs_width), 30);
        if (!s_hs && prev_shs) s_hs_width = 0;
        if (!s_hs) s_hs_width++;
        if (s_hs && !prev_shs) chk("s_hs_width", 32'(s_hs_width), 3);
        prev_dhs = d_hs; prev_shs = s_hs; prev_svs = s_vs;
    endtask

    initial begin
        cyc = 0;
        rst = 1'b1;
        #3;
        chk_reset_state();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        model_restart();

        tick_check();
        chk("first_x", 32'(d_x), 1);

        // Two full default lines and about thirteen small frames.
        for (int i = 0; i < 2200; i++) tick_check();
        chk("d_line2_y", 32'(d_y), 2);

        // Bring the small instance to (5,3), then reset asynchronously mid-frame.
        for (int i = 0; i < 200 && !(sx == 5 && sy == 3); i++) tick_check();
        chk("mid_pos_x", 32'(s_x), 5);
        chk("mid_pos_y", 32'(s_y), 3);
        #2 rst = 1'b1;
        #1 chk_reset_state();
        @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        model_restart();
        tick_check();
        chk("restart_x", 32'(d_x), 1);
        for (int i = 0; i < 1100; i++) tick_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
